// File: rtl/stage_controller_if.sv
// stage_controller_if
//   Bundles the stage controller's request/status signals.
//   Ports (master = controller side):
//     start        in   one-cycle run request, all context measurements present
//     result_ack   in   consumer has taken the result
//     pe_busy      in   [NUM_PE] per-PE busy flags
//     pe_odd       in   [NUM_PE] per-PE odd-cluster flags
//     global_stage out  [STAGE_WIDTH] registered stage broadcast
//     context_id   out  [CTX_W] context currently resident in the PEs
//     iteration    out  [ITER_W] completed grow/merge iterations
//     result_valid out  high while the stage is RESULT_VALID
//     ctrl_busy    out  high while the stage is not IDLE
//     overflow     out  sticky iteration / merge-length cap flag
interface stage_controller_if #(
  parameter int NUM_PE      = 64,
  parameter int CTX_W       = 1,
  parameter int ITER_W      = 5,
  parameter int STAGE_WIDTH = 3
);
  logic                   start;
  logic                   result_ack;
  logic [NUM_PE-1:0]      pe_busy;
  logic [NUM_PE-1:0]      pe_odd;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic [CTX_W-1:0]       context_id;
  logic [ITER_W-1:0]      iteration;
  logic                   result_valid;
  logic                   ctrl_busy;
  logic                   overflow;

  modport master (
    input  start, result_ack, pe_busy, pe_odd,
    output global_stage, context_id, iteration, result_valid, ctrl_busy, overflow
  );

  modport slave (
    output start, result_ack, pe_busy, pe_odd,
    input  global_stage, context_id, iteration, result_valid, ctrl_busy, overflow
  );
endinterface

// File: rtl/stage_controller.sv
// stage_controller
//   Sequences the PE array through load, grow/merge iterations over all
//   time-multiplexed contexts, peeling, and result hand-off.
//   Ports:
//     clk    in  clock
//     reset  in  synchronous active-high reset
//     bus    stage_controller_if.master (start/result_ack/pe_busy/pe_odd in,
//            global_stage/context_id/iteration/result_valid/ctrl_busy/overflow out)
//   Stage encodings: IDLE=0, MEASUREMENT_LOADING=1, GROW=2, MERGE=3,
//   WRITE_TO_MEM=4, PEELING=5, RESULT_VALID=6.
module stage_controller #(
  parameter int NUM_PE       = 64,
  parameter int NUM_CONTEXTS = 2,
  parameter int MAX_ITER     = 31,
  parameter int MERGE_QUIET  = 2,
  parameter int MERGE_MAX    = 255
) (
  input  logic               clk,
  input  logic               reset,
  stage_controller_if.master bus
);
  localparam int ITER_W      = $clog2(MAX_ITER + 1);
  localparam int CTX_W       = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1;
  localparam int MCNT_W      = $clog2(MERGE_MAX + 1);
  localparam int QCNT_W      = $clog2(MERGE_QUIET + 1);
  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM        = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd6;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_GROW   = 3'd2;
  localparam logic [2:0] S_MERGE  = 3'd3;
  localparam logic [2:0] S_SWAP_G = 3'd4;
  localparam logic [2:0] S_PEEL   = 3'd5;
  localparam logic [2:0] S_SWAP_P = 3'd6;
  localparam logic [2:0] S_RESULT = 3'd7;

  logic [2:0]             state_q, state_d;
  logic [STAGE_WIDTH-1:0] stage_q, stage_d;
  logic [CTX_W-1:0]       ctx_q, ctx_d;
  logic [ITER_W-1:0]      iter_q, iter_d;
  logic                   ovf_q, ovf_d;
  logic                   odd_seen_q, odd_seen_d;
  logic [MCNT_W-1:0]      mcnt_q, mcnt_d;
  logic [QCNT_W-1:0]      quiet_q, quiet_d;
  logic                   busy_any_q, odd_any_q;

  logic [NUM_PE-1:0]      busy_w, odd_w;
  logic                   iter_end, odd_eff, quiet_done, cap_hit;

  assign busy_w = bus.pe_busy;
  assign odd_w  = bus.pe_odd;

  always_comb begin
    state_d    = state_q;
    ctx_d      = ctx_q;
    iter_d     = iter_q;
    ovf_d      = ovf_q;
    odd_seen_d = odd_seen_q;
    mcnt_d     = mcnt_q;
    quiet_d    = quiet_q;
    iter_end   = 1'b0;
    odd_eff    = odd_seen_q;
    quiet_done = 1'b0;
    cap_hit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Round state is cleared on the way into LOAD so the previous
        // round's iteration/overflow stay readable while idle.
        if (bus.start) begin
          state_d    = S_LOAD;
          ctx_d      = '0;
          iter_d     = '0;
          ovf_d      = 1'b0;
          odd_seen_d = 1'b0;
        end
      end
      S_LOAD: state_d = S_GROW;
      S_GROW: begin
        state_d = S_MERGE;
        mcnt_d  = '0;
        quiet_d = '0;
      end
      S_MERGE: begin
        mcnt_d = mcnt_q + MCNT_W'(1);
        // busy_any is not trusted for the first two cycles: it still
        // reflects PE activity from before the merge began.
        if (mcnt_q >= MCNT_W'(2)) begin
          quiet_d    = busy_any_q ? '0 : quiet_q + QCNT_W'(1);
          quiet_done = !busy_any_q && (quiet_q == QCNT_W'(MERGE_QUIET - 1));
        end
        cap_hit = (mcnt_q == MCNT_W'(MERGE_MAX - 1));
        if (quiet_done || cap_hit) begin
          if (cap_hit) ovf_d = 1'b1;
          odd_seen_d = odd_seen_q | odd_any_q;
          if (NUM_CONTEXTS == 1) begin
            iter_end = 1'b1;
            odd_eff  = odd_seen_q | odd_any_q;
          end else begin
            state_d = S_SWAP_G;
            ctx_d   = ctx_q + CTX_W'(1);
          end
        end
      end
      S_SWAP_G: begin
        // context_id already advanced on entry; wrap to 0 means every
        // context has finished this iteration.
        if (ctx_q != '0) state_d = S_GROW;
        else             iter_end = 1'b1;
      end
      S_PEEL: begin
        if (NUM_CONTEXTS == 1) state_d = S_RESULT;
        else begin
          state_d = S_SWAP_P;
          ctx_d   = ctx_q + CTX_W'(1);
        end
      end
      S_SWAP_P: state_d = (ctx_q != '0) ? S_PEEL : S_RESULT;
      S_RESULT: if (bus.result_ack) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Iteration bookkeeping; the cap is judged on the incremented count, so
    // at most MAX_ITER grow/merge passes are run.
    if (iter_end) begin
      iter_d = (iter_q == ITER_W'(MAX_ITER)) ? iter_q : iter_q + ITER_W'(1);
      if (odd_eff && (iter_d != ITER_W'(MAX_ITER))) begin
        state_d    = S_GROW;
        odd_seen_d = 1'b0;
      end else begin
        if (odd_eff) ovf_d = 1'b1;
        state_d = S_PEEL;
      end
    end
  end

  always_comb begin
    stage_d = STAGE_IDLE;
    case (state_d)
      S_IDLE:            stage_d = STAGE_IDLE;
      S_LOAD:            stage_d = STAGE_MEASUREMENT_LOADING;
      S_GROW:            stage_d = STAGE_GROW;
      S_MERGE:           stage_d = STAGE_MERGE;
      S_SWAP_G, S_SWAP_P: stage_d = STAGE_WRITE_TO_MEM;
      S_PEEL:            stage_d = STAGE_PEELING;
      S_RESULT:          stage_d = STAGE_RESULT_VALID;
      default:           stage_d = STAGE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      stage_q    <= STAGE_IDLE;
      ctx_q      <= '0;
      iter_q     <= '0;
      ovf_q      <= 1'b0;
      odd_seen_q <= 1'b0;
      mcnt_q     <= '0;
      quiet_q    <= '0;
      busy_any_q <= 1'b0;
      odd_any_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      ctx_q      <= ctx_d;
      iter_q     <= iter_d;
      ovf_q      <= ovf_d;
      odd_seen_q <= odd_seen_d;
      mcnt_q     <= mcnt_d;
      quiet_q    <= quiet_d;
      busy_any_q <= |busy_w;
      odd_any_q  <= |odd_w;
    end
  end

  assign bus.global_stage = stage_q;
  assign bus.context_id   = ctx_q;
  assign bus.iteration    = iter_q;
  assign bus.overflow     = ovf_q;
  assign bus.result_valid = (stage_q == STAGE_RESULT_VALID);
  assign bus.ctrl_busy    = (stage_q != STAGE_IDLE);
endmodule

// File: tb/tb_stage_controller.sv
// tb_stage_controller
//   Two controllers share one stimulus stream: dut0 with two contexts, dut1
//   with one. Only the selected one runs; the other is held in reset. A
//   procedural round model walks the expected stage sequence and checks
//   every cycle's outputs.
module tb_stage_controller;
  localparam int NPE   = 64;
  localparam int MAXIT = 31;
  localparam int MQ    = 2;
  localparam int MMAX  = 255;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_GROW = 3'd2,
                         ST_MERGE = 3'd3, ST_WMEM = 3'd4, ST_PEEL = 3'd5,
                         ST_RES = 3'd6;

  localparam int PH_RUN = 0, PH_HOLD = 1, PH_ACK = 2, PH_IDLE = 3, PH_GO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           start_i, ack_i;
  logic [NPE-1:0] busy_v, odd_v;
  logic           sel;

  stage_controller_if #(.NUM_PE(NPE), .CTX_W(1), .ITER_W(5)) if0 ();
  stage_controller_if #(.NUM_PE(NPE), .CTX_W(1), .ITER_W(5)) if1 ();

  assign if0.start = start_i;  assign if1.start = start_i;
  assign if0.result_ack = ack_i; assign if1.result_ack = ack_i;
  assign if0.pe_busy = busy_v; assign if1.pe_busy = busy_v;
  assign if0.pe_odd = odd_v;   assign if1.pe_odd = odd_v;

  stage_controller #(.NUM_PE(NPE), .NUM_CONTEXTS(2), .MAX_ITER(MAXIT),
                     .MERGE_QUIET(MQ), .MERGE_MAX(MMAX))
    dut0 (.clk(clk), .reset(sel ? 1'b1 : rst), .bus(if0));
  stage_controller #(.NUM_PE(NPE), .NUM_CONTEXTS(1), .MAX_ITER(MAXIT),
                     .MERGE_QUIET(MQ), .MERGE_MAX(MMAX))
    dut1 (.clk(clk), .reset(sel ? rst : 1'b1), .bus(if1));

  logic [2:0] o_stage;
  logic [0:0] o_ctx;
  logic [4:0] o_iter;
  logic       o_rv, o_busy, o_ovf;
  assign o_stage = sel ? if1.global_stage : if0.global_stage;
  assign o_ctx   = sel ? if1.context_id   : if0.context_id;
  assign o_iter  = sel ? if1.iteration    : if0.iteration;
  assign o_rv    = sel ? if1.result_valid : if0.result_valid;
  assign o_busy  = sel ? if1.ctrl_busy    : if0.ctrl_busy;
  assign o_ovf   = sel ? if1.overflow     : if0.overflow;

  int n_chk = 0;
  int n_fail = 0;

  // Model state.
  int it;
  bit ov, oseen, bz, od;
  int ph_m;
  int busy_pct, odd_pct, odd_lim, busy_hold, res_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_state(input string tag, input logic [2:0] stg, input int ctx);
    check({tag, ".stage"}, 32'(o_stage), 32'(stg));
    check({tag, ".ctx"}, 32'(o_ctx), 32'(ctx));
    check({tag, ".iter"}, 32'(o_iter), 32'(it));
    check({tag, ".ovf"}, 32'(o_ovf), 32'(ov));
    check({tag, ".rv"}, 32'(o_rv), 32'(stg == ST_RES));
    check({tag, ".busy"}, 32'(o_busy), 32'(stg != ST_IDLE));
  endtask

  task automatic drive(input int ph);
    busy_v = '0;
    odd_v  = '0;
    if (ph_m >= 0 && ph_m < busy_hold) busy_v = '1;
    else if ($urandom_range(99) < busy_pct) busy_v[$urandom_range(NPE-1)] = 1'b1;
    if (it < odd_lim || $urandom_range(99) < odd_pct) odd_v[$urandom_range(NPE-1)] = 1'b1;
    case (ph)
      PH_HOLD: begin start_i = 1'($urandom_range(1)); ack_i = 1'b0; end
      PH_ACK:  begin start_i = 1'($urandom_range(1)); ack_i = 1'b1; end
      PH_IDLE: begin start_i = 1'b0; ack_i = 1'($urandom_range(1)); end
      PH_GO:   begin start_i = 1'b1; ack_i = 1'($urandom_range(1)); end
      default: begin start_i = 1'($urandom_range(1)); ack_i = 1'($urandom_range(1)); end
    endcase
  endtask

  // One clock; afterwards bz/od hold what the registered ORs now show.
  task automatic tick();
    bit nb, no;
    nb = |busy_v;
    no = |odd_v;
    @(posedge clk);
    #1;
    bz = nb;
    od = no;
  endtask

  task automatic do_merge(input int c, input bit rst_c1, output bit ab);
    int m, q;
    bit done, cap;
    ab = 1'b0; m = 0; q = 0; done = 1'b0; cap = 1'b0;
    ph_m = -1;
    drive(PH_RUN); tick(); expect_state("merge", ST_MERGE, c);
    while (!done) begin
      cap = (m == MMAX - 1);
      if (m >= 2) q = bz ? 0 : q + 1;
      done = (q >= MQ) || cap;
      if (!done) begin
        if (rst_c1 && c == 1 && m == 2) begin
          rst = 1'b1;
          drive(PH_RUN); start_i = 1'b1; ack_i = 1'b1;
          tick();
          rst = 1'b0;
          it = 0; ov = 1'b0; ph_m = -1;
          expect_state("rst_merge", ST_IDLE, 0);
          ab = 1'b1;
          return;
        end
        ph_m = m;
        drive(PH_RUN); tick(); m++;
        expect_state("merge", ST_MERGE, c);
      end
    end
    ph_m = -1;
    oseen |= od;
    if (cap) ov = 1'b1;
  endtask

  task automatic run_round(input int nc, input bit rst_c1);
    bit ab, more;
    int n;
    drive(PH_GO); tick();
    it = 0; ov = 1'b0;
    expect_state("load", ST_LOAD, 0);
    more = 1'b1;
    while (more) begin
      oseen = 1'b0;
      for (int c = 0; c < nc; c++) begin
        drive(PH_RUN); tick(); expect_state("grow", ST_GROW, c);
        do_merge(c, rst_c1, ab);
        if (ab) return;
        if (nc > 1) begin
          drive(PH_RUN); tick(); expect_state("swap_g", ST_WMEM, (c + 1) % nc);
        end
      end
      if (it < MAXIT) it++;
      more = oseen && (it < MAXIT);
      if (oseen && !more) ov = 1'b1;
    end
    for (int c = 0; c < nc; c++) begin
      drive(PH_RUN); tick(); expect_state("peel", ST_PEEL, c);
      if (nc > 1) begin
        drive(PH_RUN); tick(); expect_state("swap_p", ST_WMEM, (c + 1) % nc);
      end
    end
    drive(PH_RUN); tick(); expect_state("result", ST_RES, 0);
    n = (res_hold < 0) ? int'($urandom_range(4)) : res_hold;
    for (int i = 0; i < n; i++) begin
      drive(PH_HOLD);
      if (i == 2) start_i = 1'b1;
      tick(); expect_state("res_hold", ST_RES, 0);
    end
    drive(PH_ACK); tick(); expect_state("ack", ST_IDLE, 0);
    drive(PH_IDLE); tick(); expect_state("idle", ST_IDLE, 0);
  endtask

  task automatic set_mode(input int bp, input int op, input int ol, input int bh, input int rh);
    busy_pct = bp; odd_pct = op; odd_lim = ol; busy_hold = bh; res_hold = rh;
  endtask

  task automatic select_dut(input logic s);
    sel = s;
    rst = 1'b1;
    drive(PH_GO); ack_i = 1'b1;
    tick(); tick();
    it = 0; ov = 1'b0;
    expect_state("reset", ST_IDLE, 0);
    rst = 1'b0;
    drive(PH_IDLE); tick();
    expect_state("post_reset", ST_IDLE, 0);
  endtask

  initial begin
    ph_m = -1; it = 0; ov = 1'b0; oseen = 1'b0; bz = 1'b0; od = 1'b0;
    start_i = 1'b0; ack_i = 1'b0; busy_v = '0; odd_v = '0; rst = 1'b1;
    set_mode(0, 0, 0, 0, 0);

    // Single-context controller.
    select_dut(1'b1);
    set_mode(0, 0, 0, 0, 0);
    run_round(1, 1'b0);
    check("nc1_iter", 32'(o_iter), 32'd1);
    check("nc1_ovf", 32'(o_ovf), 32'd0);
    set_mode(30, 40, 0, 0, -1);
    for (int r = 0; r < 4; r++) run_round(1, 1'b0);
    set_mode(0, 0, 99, 0, 1);
    run_round(1, 1'b0);
    check("nc1_sat_iter", 32'(o_iter), 32'd31);

    // Two-context controller.
    select_dut(1'b0);
    set_mode(0, 0, 1, 0, 0);
    run_round(2, 1'b0);
    check("two_ctx_iter", 32'(o_iter), 32'd2);
    check("two_ctx_ovf", 32'(o_ovf), 32'd0);
    set_mode(0, 0, 0, 10, 0);
    run_round(2, 1'b0);
    set_mode(0, 0, 99, 0, 0);
    run_round(2, 1'b0);
    check("sat_iter", 32'(o_iter), 32'd31);
    check("sat_ovf", 32'(o_ovf), 32'd1);
    set_mode(0, 0, 0, 0, 0);
    run_round(2, 1'b1);
    run_round(2, 1'b0);
    check("after_rst_iter", 32'(o_iter), 32'd1);
    set_mode(20, 0, 0, 0, 5);
    run_round(2, 1'b0);
    set_mode(100, 0, 0, 0, 0);
    run_round(2, 1'b0);
    check("merge_cap_ovf", 32'(o_ovf), 32'd1);
    set_mode(30, 35, 0, 0, -1);
    for (int r = 0; r < 6; r++) run_round(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/stage_controller.md
STAGE_CONTROLLER -- requirements
Module: stage_controller

Interface
REQ-001 Parameter NUM_PE, 64, number of processing units observed.
REQ-002 Parameter NUM_CONTEXTS, 2, contexts time-multiplexed per PE (power of two, >=1).
REQ-003 Parameter MAX_ITER, 31, grow/merge iteration cap; ITER_W = $clog2(MAX_ITER+1).
REQ-004 Parameter MERGE_QUIET, 2, consecutive not-busy cycles that end a MERGE.
REQ-005 Parameter MERGE_MAX, 255, hard cap on cycles per MERGE.
REQ-006 Clock clk; reset reset, synchronous, active-high.
REQ-007 clk  input  1  clock.
REQ-008 reset  input  1  synchronous active-high reset.
REQ-009 start  input  1  measurements for all contexts present; one-cycle request.
REQ-010 result_ack  input  1  consumer has taken the result.
REQ-011 pe_busy  input  NUM_PE  per-PE busy flags.
REQ-012 pe_odd  input  NUM_PE  per-PE odd-cluster flags.
REQ-013 global_stage  output  STAGE_WIDTH  registered stage broadcast, shared STAGE_* encodings.
REQ-014 context_id  output  $clog2(NUM_CONTEXTS) (min 1)  context currently resident in PEs.
REQ-015 iteration  output  ITER_W  completed grow/merge iterations.
REQ-016 result_valid  output  1  high exactly while global_stage == STAGE_RESULT_VALID.
REQ-017 ctrl_busy  output  1  high whenever global_stage != STAGE_IDLE.
REQ-018 overflow  output  1  sticky: MAX_ITER or MERGE_MAX reached in this round.

Function
REQ-019 States: IDLE, LOAD, GROW, MERGE, SWAP_G, PEEL, SWAP_P, RESULT; global_stage maps to STAGE_IDLE, STAGE_MEASUREMENT_LOADING, STAGE_GROW, STAGE_MERGE, STAGE_WRITE_TO_MEM (SWAP_G/SWAP_P), STAGE_PEELING, STAGE_RESULT_VALID.
REQ-020 busy_any and odd_any are registered ORs of pe_busy/pe_odd (1-cycle latency).
REQ-021 IDLE: start=1 -> LOAD; start is ignored in every other state.
REQ-022 LOAD lasts 1 cycle; clears iteration, context_id, overflow, odd_seen -> GROW.
REQ-023 GROW lasts exactly 1 cycle -> MERGE.
REQ-024 MERGE: cycle counter from 0; exit once busy_any==0 for MERGE_QUIET consecutive cycles, ignoring busy_any in the first 2 MERGE cycles; on the exit cycle, odd_seen |= odd_any.
REQ-025 MERGE reaching MERGE_MAX cycles exits as in REQ-024 and sets overflow.
REQ-026 MERGE exit: NUM_CONTEXTS==1 -> iteration-end check; otherwise -> SWAP_G.
REQ-027 SWAP_G lasts 1 cycle; context_id increments mod NUM_CONTEXTS; if the new context_id != 0 -> GROW, else iteration-end check.
REQ-028 Iteration-end check: iteration increments (saturating at MAX_ITER); odd_seen==1 and iteration < MAX_ITER -> GROW with odd_seen cleared; odd_seen==1 at MAX_ITER -> set overflow, PEEL; odd_seen==0 -> PEEL.
REQ-029 PEEL lasts 1 cycle; NUM_CONTEXTS==1 -> RESULT; otherwise -> SWAP_P.
REQ-030 SWAP_P lasts 1 cycle, increments context_id; new context_id != 0 -> PEEL, else -> RESULT.
REQ-031 RESULT holds for at least 1 cycle until result_ack=1 -> IDLE; result_ack outside RESULT is ignored.
REQ-032 context_id is always 0 on entry to RESULT and IDLE.
REQ-033 global_stage changes only on clock edges; exactly one stage per cycle; no combinational paths from inputs to outputs.

Reset
REQ-034 reset=1 in any state forces IDLE on the next edge: global_stage=STAGE_IDLE, context_id=0, iteration=0, result_valid=0, ctrl_busy=0, overflow=0; internal counters and odd_seen cleared.
REQ-035 reset overrides start and result_ack when asserted in the same cycle.

Verification
REQ-036 NUM_CONTEXTS=1, start, pe_odd=0, pe_busy=0 -> LOAD, GROW, MERGE x4, PEEL, RESULT; iteration=1, overflow=0.
REQ-037 NUM_CONTEXTS=2, one PE odd through iteration 1 only -> sequence per iteration GROW, MERGE, SWAP_G, GROW, MERGE, SWAP_G; iteration=2; then PEEL, SWAP_P, PEEL, SWAP_P, RESULT with context_id=0.
REQ-038 pe_busy held high 10 cycles into MERGE -> MERGE ends exactly MERGE_QUIET+1 cycles after busy drops (includes the 1-cycle reduction latency).
REQ-039 pe_odd stuck high -> iteration saturates at 31, overflow=1, PEEL entered, RESULT reached.
REQ-040 reset pulsed during MERGE of context 1 -> next cycle IDLE with all outputs at reset values; a later start runs cleanly from LOAD.
REQ-041 In RESULT, result_ack withheld 5 cycles -> result_valid stays 1; start pulse ignored; ack -> IDLE next cycle.
